// File: rtl/parking_entry_terminal_pkg.sv
// Shared types and constants for the parking entry terminal.
//   state_e   : terminal FSM states (3-bit encoding)
//   DIGIT_W   : width of one BCD keypad digit
//   NUM_DIGITS: digits per access code
//   CODE_W    : width of the assembled code
//   BCD_MAX   : largest legal keypad digit
package parking_entry_terminal_pkg;

   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 4;
   localparam int CODE_W     = DIGIT_W * NUM_DIGITS;
   localparam int BCD_MAX    = 9;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COLLECT   = 3'd1,
      ST_SUBMIT    = 3'd2,
      ST_WAIT_RESP = 3'd3,
      ST_OPENING   = 3'd4,
      ST_OPEN      = 3'd5,
      ST_CLOSING   = 3'd6,
      ST_LOCKED    = 3'd7
   } state_e;

   function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
      return d <= DIGIT_W'(BCD_MAX);
   endfunction

endpackage

// File: rtl/parking_entry_terminal_if.sv
// Request/verdict channel between the entry terminal and the parking
// controller.
//   vehicle_arrival : terminal -> controller, one-cycle, code valid
//   code            : terminal -> controller, assembled BCD code
//   vehicle_left    : terminal -> controller, one-cycle, car cleared beam
//   open_gate       : controller -> terminal, code accepted
//   wrong_ping      : controller -> terminal, code rejected
//   close_gate      : controller -> terminal, lower barrier
//   blocked_gate    : controller -> terminal, lockout level
interface parking_entry_terminal_if;
   import parking_entry_terminal_pkg::*;

   logic              vehicle_arrival;
   logic [CODE_W-1:0] code;
   logic              vehicle_left;
   logic              open_gate;
   logic              wrong_ping;
   logic              close_gate;
   logic              blocked_gate;

   modport master (
      output vehicle_arrival, code, vehicle_left,
      input  open_gate, wrong_ping, close_gate, blocked_gate
   );

   modport slave (
      input  vehicle_arrival, code, vehicle_left,
      output open_gate, wrong_ping, close_gate, blocked_gate
   );

endinterface

// File: rtl/parking_entry_terminal_gate_travel_timer.sv
// Loadable down-counter used for barrier travel time and keypad timeout.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load i_load_val (wins over counting)
//   i_load_val   : cycles to run
//   o_busy       : counter non-zero
//   o_done       : last counted cycle (count == 1)
module gate_travel_timer #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_busy,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)               r_cnt <= '0;
      else if (i_load)         r_cnt <= i_load_val;
      else if (r_cnt != '0)    r_cnt <= r_cnt - W'(1);
   end

   assign o_busy = (r_cnt != '0);
   assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/parking_entry_terminal.sv
// Entry-side parking terminal: collects a 4-digit BCD code from the keypad,
// submits it to the controller, drives the barrier motor on the verdict and
// reports when the car has cleared the exit beam.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_car_sensor   : entrance loop, high while a car is present
//   i_exit_sensor  : beam past the barrier, high while broken
//   i_key_valid    : one-cycle keypad strobe with i_key_digit
//   ctl_if         : controller request/verdict channel (master side)
//   o_motor_up     : barrier raise drive
//   o_motor_down   : barrier lower drive
//   o_key_error    : one-cycle pulse after a non-BCD digit
module parking_entry_terminal
   import parking_entry_terminal_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 8,
   parameter int KEY_TIMEOUT   = 64
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_car_sensor,
   input  logic                     i_exit_sensor,
   input  logic                     i_key_valid,
   input  logic [DIGIT_W-1:0]       i_key_digit,
   parking_entry_terminal_if.master ctl_if,
   output logic                     o_motor_up,
   output logic                     o_motor_down,
   output logic                     o_key_error
);

   localparam int TW = $clog2(TRAVEL_CYCLES + 1);
   localparam int KW = $clog2(KEY_TIMEOUT + 1);
   localparam int CW = $clog2(NUM_DIGITS + 1);

   state_e            r_state, w_next;
   logic [CODE_W-1:0] r_sr, r_code;
   logic [CW-1:0]     r_cnt;
   logic              r_arrival, r_left, r_key_err;
   logic              r_gap;        // dead cycle between motor_down and motor_up
   logic              r_closed;     // barrier known fully down
   logic              r_seen_beam, r_left_done;
   logic              w_trav_load, w_trav_done, w_trav_busy;
   logic              w_key_load, w_key_done, w_key_busy;
   logic              w_unused_busy;
   logic              w_lock, w_digit_ok, w_key_bad;

   assign w_lock     = ctl_if.blocked_gate;
   assign w_digit_ok = i_key_valid &&  is_bcd(i_key_digit);
   assign w_key_bad  = i_key_valid && !is_bcd(i_key_digit);

   gate_travel_timer #(.W(TW)) u_travel_tmr (
      .i_clk(i_clk), .i_rst(i_rst), .i_load(w_trav_load),
      .i_load_val(TW'(TRAVEL_CYCLES)), .o_busy(w_trav_busy), .o_done(w_trav_done)
   );

   gate_travel_timer #(.W(KW)) u_key_tmr (
      .i_clk(i_clk), .i_rst(i_rst), .i_load(w_key_load),
      .i_load_val(KW'(KEY_TIMEOUT)), .o_busy(w_key_busy), .o_done(w_key_done)
   );

   assign w_unused_busy = w_trav_busy | w_key_busy;

   always_comb begin
      w_next      = r_state;
      w_trav_load = 1'b0;
      w_key_load  = 1'b0;
      if (w_lock) begin
         w_next = ST_LOCKED;
      end else begin
         case (r_state)
            ST_IDLE: if (i_car_sensor) begin
               w_next     = ST_COLLECT;
               w_key_load = 1'b1;
            end
            ST_COLLECT: begin
               if (!i_car_sensor) begin
                  w_next = ST_IDLE;
               end else if (i_key_valid) begin
                  w_key_load = 1'b1;
                  if (w_digit_ok && r_cnt == CW'(NUM_DIGITS - 1)) w_next = ST_SUBMIT;
               end else if (w_key_done) begin
                  w_next = ST_IDLE;
               end
            end
            ST_SUBMIT: w_next = ST_WAIT_RESP;
            // Reject wins when both verdicts arrive together.
            ST_WAIT_RESP: begin
               if (ctl_if.wrong_ping) begin
                  w_next     = ST_COLLECT;
                  w_key_load = 1'b1;
               end else if (ctl_if.open_gate) begin
                  w_next      = ST_OPENING;
                  w_trav_load = 1'b1;
               end
            end
            // After a reversal the travel timer is reloaded once the dead
            // cycle has passed, so the raise still gets a full travel.
            ST_OPENING: begin
               if (r_gap)            w_trav_load = 1'b1;
               else if (w_trav_done) w_next = ST_OPEN;
            end
            ST_OPEN: if (r_left_done && ctl_if.close_gate) begin
               w_next      = ST_CLOSING;
               w_trav_load = 1'b1;
            end
            ST_CLOSING: begin
               if (i_exit_sensor)    w_next = ST_OPENING;
               else if (w_trav_done) w_next = ST_IDLE;
            end
            ST_LOCKED: begin
               if (r_closed) begin
                  w_next = ST_IDLE;
               end else begin
                  w_next      = ST_CLOSING;
                  w_trav_load = 1'b1;
               end
            end
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_sr        <= '0;
         r_code      <= '0;
         r_cnt       <= '0;
         r_arrival   <= 1'b0;
         r_left      <= 1'b0;
         r_key_err   <= 1'b0;
         r_gap       <= 1'b0;
         r_closed    <= 1'b1;
         r_seen_beam <= 1'b0;
         r_left_done <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_arrival <= (r_state == ST_SUBMIT) && !w_lock;
         r_key_err <= (r_state == ST_COLLECT) && i_car_sensor && w_key_bad && !w_lock;
         r_gap     <= (r_state == ST_CLOSING) && (w_next == ST_OPENING);

         if (r_state == ST_SUBMIT && !w_lock) r_code <= r_sr;

         if (r_state == ST_COLLECT && i_car_sensor && !w_lock && w_digit_ok) begin
            r_sr  <= {r_sr[CODE_W-DIGIT_W-1:0], i_key_digit};
            r_cnt <= r_cnt + CW'(1);
         end else if ((w_next == ST_COLLECT && r_state != ST_COLLECT) ||
                      (r_state == ST_COLLECT && w_next == ST_IDLE)) begin
            r_sr  <= '0;
            r_cnt <= '0;
         end

         if (w_next == ST_OPENING)                             r_closed <= 1'b0;
         else if (r_state == ST_CLOSING && w_next == ST_IDLE)  r_closed <= 1'b1;

         // Beam must be seen high then low before the car counts as gone.
         r_left <= (r_state == ST_OPEN) && r_seen_beam && !i_exit_sensor &&
                   !r_left_done && !w_lock;
         if (r_state != ST_OPEN) begin
            r_seen_beam <= 1'b0;
            r_left_done <= 1'b0;
         end else if (i_exit_sensor) begin
            r_seen_beam <= 1'b1;
         end else if (r_seen_beam) begin
            r_left_done <= 1'b1;
         end
      end
   end

   assign o_motor_up             = (r_state == ST_OPENING) && !r_gap;
   assign o_motor_down           = (r_state == ST_CLOSING);
   assign o_key_error            = r_key_err;
   assign ctl_if.vehicle_arrival = r_arrival;
   assign ctl_if.code            = r_code;
   assign ctl_if.vehicle_left    = r_left;

endmodule

// File: doc/parking_entry_terminal.md
Name: parking_entry_terminal

Overview:
- Entry-side terminal that drives the parking controller's request interface: vehicle_arrival, code and vehicle_left.
- It acts on the controller's verdicts (open_gate, wrong_ping, close_gate, blocked_gate).
- Collects BCD keypad digits, submits a 16-bit code, runs the gate barrier motor with a travel timer, and reports when the vehicle has passed.
- Sits between physical I/O (car loop, exit beam, keypad, barrier motor) and the parking controller.

Parameters:
- TRAVEL_CYCLES, 8, cycles of motor drive for a full barrier open or close (>=2).
- KEY_TIMEOUT, 64, idle cycles allowed between keypad digits before entry is abandoned.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- car_sensor  in  1  entrance loop detector, high while a car is present
- exit_sensor  in  1  beam past the barrier, high while a car breaks it
- key_valid  in  1  one-cycle keypad strobe
- key_digit  in  4  digit accompanying key_valid
- open_gate  in  1  controller: code accepted
- wrong_ping  in  1  controller: code rejected
- close_gate  in  1  controller: lower barrier
- blocked_gate  in  1  controller: lockout, level
- vehicle_arrival  out  1  one-cycle pulse, code valid this cycle
- code  out  16  assembled BCD code, first digit in [15:12]
- vehicle_left  out  1  one-cycle pulse when the car has cleared the beam
- motor_up  out  1  barrier raise drive
- motor_down  out  1  barrier lower drive
- key_error  out  1  one-cycle pulse on a non-BCD digit (>9)

Behaviour:
- Reset: all outputs 0, code=16'h0000, state IDLE, digit count 0, timers cleared. Reset mid-travel stops the motor immediately with no re-homing.
- States: IDLE, COLLECT, SUBMIT, WAIT_RESP, OPENING, OPEN, CLOSING, LOCKED.
- IDLE -> COLLECT when car_sensor=1. Digit count and shift register are cleared.
- COLLECT, digit accepted (key_valid=1, key_digit<=9):
  - shift register <= {sr[11:0], key_digit}; count++.
  - The timeout counter reloads on every key_valid.
- COLLECT, other events:
  - key_digit>9: key_error pulse the next cycle; the digit is dropped; count unchanged.
  - After the 4th valid digit -> SUBMIT.
  - Timeout expiry or car_sensor=0 -> IDLE with the shift register cleared.
- SUBMIT, exactly one cycle:
  - code <= shift register, registered.
  - vehicle_arrival=1 in the same cycle code first shows the new value.
  - Next state is WAIT_RESP.
  - code holds until the next SUBMIT or reset.
- WAIT_RESP:
  - open_gate -> OPENING.
  - wrong_ping -> COLLECT with count cleared, so the driver re-enters the code.
  - key_valid is ignored. No timeout: the controller must answer.
- OPENING: motor_up=1 for exactly TRAVEL_CYCLES cycles, then OPEN.
- OPEN:
  - Waits for exit_sensor to rise then fall. On the cycle after the falling edge, vehicle_left pulses for one cycle.
  - Then waits for close_gate -> CLOSING.
  - close_gate arriving before vehicle_left is ignored.
- CLOSING:
  - motor_down=1 for TRAVEL_CYCLES, then IDLE.
  - Safety reversal: if exit_sensor=1 during CLOSING -> OPENING with the full timer reload. motor_down drops the same cycle and motor_up rises the next cycle.
- motor_up and motor_down are never both 1. At least one cycle with both at 0 separates the directions.
- blocked_gate=1 in any state -> LOCKED next cycle. This takes priority over open_gate, wrong_ping and close_gate in the same cycle.
- LOCKED:
  - All outputs 0; keys are ignored.
  - Exit to IDLE when blocked_gate=0.
  - If the barrier was not fully closed, LOCKED exits to CLOSING instead, with a full travel.
- open_gate and wrong_ping both high in one cycle: treated as wrong_ping.
- Pulse outputs are registered. No output is combinational from inputs.

Decomposition:
- Shared package: state enum (3 bits), DIGIT_W=4, NUM_DIGITS=4, CODE_W=16, BCD_MAX=9.
- Sub-module gate_travel_timer: loadable down-counter with load/busy/done.
  - Used for motor travel and reused for the key timeout via a second instance.

Test Plan:
- Happy path:
  - Stimulus: car_sensor=1; keys 1,2,3,4; open_gate; exit_sensor pulses 3 cycles; close_gate.
  - Response:
    - vehicle_arrival pulses once with code=16'h1234.
    - motor_up high 8 cycles.
    - vehicle_left pulses once, the cycle after exit_sensor falls.
    - motor_down high 8 cycles, then IDLE.
- Wrong code:
  - Stimulus: keys 9,9,9,9 then wrong_ping; re-enter 1,2,3,4.
  - Response: first code=16'h9999; second vehicle_arrival with code=16'h1234; no motor activity until open_gate.
- Bad digit / timeout:
  - Stimulus: key 4'hA mid-entry; separately, 64 idle cycles after 2 digits.
  - Response: key_error single pulse with count unchanged; timeout returns to IDLE with no vehicle_arrival.
- Lockout priority:
  - Stimulus: blocked_gate and open_gate high in the same WAIT_RESP cycle.
  - Response: LOCKED, motor_up stays 0 until blocked_gate drops, then IDLE.
- Safety reversal:
  - Stimulus: exit_sensor=1 at CLOSING cycle 3.
  - Response: motor_down drops, motor_up asserts the next cycle for 8 cycles, never overlapping.
- Reset mid-OPENING:
  - Stimulus: rst=1 for 1 cycle at OPENING cycle 4.
  - Response: next cycle all outputs 0, code=16'h0000, state IDLE.
